cordic_rotator_iter: RTL and testbench

- Iterative rotation-mode CORDIC. It is the inverse of the vectoring micro-rotation stages.
- Given a vector (x, y) and a target angle, it rotates the vector by that angle and drives the residual angle toward zero.
- It uses one shared shift/add datapath for ITER clock cycles per operation, with a start/busy/done handshake.
- It sits beside the vectoring pipeline and generates sin/cos and rotated vectors for the same 12-bit signed fixed-point formats.

---
 rtl/cordic_rotator_iter.sv | 149 ++++++++++++++
 tb/tb_cordic_rotator_iter.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/cordic_rotator_iter.sv
// Iterative rotation-mode CORDIC: one shift/add micro-rotation per clock,
// start/busy/done handshake, saturated 12-bit outputs, unscaled by K.
module cordic_rotator_iter #(
    parameter int unsigned ITER  = 10,
    parameter int unsigned GUARD = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic signed [11:0] x_in,
    input  logic signed [11:0] y_in,
    input  logic signed [11:0] theda_in,
    output logic              busy,
    output logic              done,
    output logic signed [11:0] x_out,
    output logic signed [11:0] y_out,
    output logic signed [11:0] theda_out
);

    localparam int unsigned DW = 12;
    localparam int unsigned XW = DW + GUARD;
    localparam int unsigned CW = 4;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam logic signed [XW-1:0] SAT_MAX = XW'(2047);
    localparam logic signed [XW-1:0] SAT_MIN = XW'(-2048);

    logic [1:0]           state, state_nxt;
    logic [CW-1:0]        iter_cnt;
    logic signed [XW-1:0] xr, yr;
    logic signed [XW-1:0] x_step, y_step, x_nxt, y_nxt;
    logic signed [DW-1:0] zr, z_nxt;
    logic [DW-1:0]        atan_val;
    logic                 load_c, last_c;

    // round(atan(2^-i) * 1024)
    function automatic logic [DW-1:0] atan_lut(input logic [CW-1:0] idx);
        case (idx)
            4'd0:    return DW'(804);
            4'd1:    return DW'(475);
            4'd2:    return DW'(251);
            4'd3:    return DW'(127);
            4'd4:    return DW'(64);
            4'd5:    return DW'(32);
            4'd6:    return DW'(16);
            4'd7:    return DW'(8);
            4'd8:    return DW'(4);
            4'd9:    return DW'(2);
            4'd10:   return DW'(1);
            default: return DW'(0);
        endcase
    endfunction

    function automatic logic signed [DW-1:0] sat(input logic signed [XW-1:0] v);
        if (v > SAT_MAX) return DW'(SAT_MAX);
        if (v < SAT_MIN) return DW'(SAT_MIN);
        return v[DW-1:0];
    endfunction

    // One micro-rotation; direction follows the sign of the residual angle
    always_comb begin
        atan_val = atan_lut(iter_cnt);
        x_step   = xr >>> iter_cnt;
        y_step   = yr >>> iter_cnt;
        if (!zr[DW-1]) begin
            x_nxt = xr - y_step;
            y_nxt = yr + x_step;
            z_nxt = zr - atan_val;
        end else begin
            x_nxt = xr + y_step;
            y_nxt = yr - x_step;
            z_nxt = zr + atan_val;
        end
    end

    // Next-state logic; DONE may accept a new operation back-to-back
    always_comb begin
        state_nxt = state;
        load_c    = 1'b0;
        last_c    = 1'b0;
        case (state)
            S_IDLE: begin
                if (start) begin
                    load_c    = 1'b1;
                    state_nxt = S_RUN;
                end
            end
            S_RUN: begin
                if (iter_cnt == CW'(ITER - 1)) begin
                    last_c    = 1'b1;
                    state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                if (start) begin
                    load_c    = 1'b1;
                    state_nxt = S_RUN;
                end else begin
                    state_nxt = S_IDLE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            state <= state_nxt;
            busy  <= (state_nxt == S_RUN);
            done  <= (state_nxt == S_DONE);
        end
    end

    // Working registers and result registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            xr        <= '0;
            yr        <= '0;
            zr        <= '0;
            iter_cnt  <= '0;
            x_out     <= '0;
            y_out     <= '0;
            theda_out <= '0;
        end else if (load_c) begin
            xr       <= XW'(x_in);
            yr       <= XW'(y_in);
            zr       <= theda_in;
            iter_cnt <= '0;
        end else if (state == S_RUN) begin
            xr       <= x_nxt;
            yr       <= y_nxt;
            zr       <= z_nxt;
            iter_cnt <= iter_cnt + CW'(1);
            if (last_c) begin
                x_out     <= sat(x_nxt);
                y_out     <= sat(y_nxt);
                theda_out <= z_nxt;
            end
        end
    end

endmodule

// File: tb/tb_cordic_rotator_iter.sv
// Self-checking bench for cordic_rotator_iter: real-valued-table CORDIC model,
// per-cycle output/handshake compare, directed and randomized operations.
module tb_cordic_rotator_iter;

    localparam int ITER = 10;

    typedef struct {
        int x;
        int y;
        int z;
    } res_t;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              start = 1'b0;
    logic signed [11:0] x_in = '0;
    logic signed [11:0] y_in = '0;
    logic signed [11:0] theda_in = '0;
    logic              busy, done;
    logic signed [11:0] x_out, y_out, theda_out;

    int   checks = 0;
    int   errors = 0;
    res_t expq[$];
    res_t held;

    cordic_rotator_iter #(.ITER(ITER), .GUARD(2)) dut (
        .clk(clk), .rst(rst), .start(start),
        .x_in(x_in), .y_in(y_in), .theda_in(theda_in),
        .busy(busy), .done(done),
        .x_out(x_out), .y_out(y_out), .theda_out(theda_out)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_rng(input string name, input int act, input int lo, input int hi);
        checks++;
        if (act < lo || act > hi) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d..%0d at %0t", name, act, lo, hi, $time);
        end
    endtask

    function automatic int wrapn(input int v, input int n);
        int half = 1 << (n - 1);
        return ((v + half) & ((1 << n) - 1)) - half;
    endfunction

    function automatic int satn(input int v);
        if (v > 2047) return 2047;
        if (v < -2048) return -2048;
        return v;
    endfunction

    function automatic int atan_ref(input int k);
        return int'($floor($atan(2.0 ** (-k)) * 1024.0 + 0.5));
    endfunction

    // Rotation-mode CORDIC in plain integer arithmetic
    function automatic res_t model(input int xi, input int yi, input int zi);
        int x = xi;
        int y = yi;
        int z = wrapn(zi, 12);
        int xs, ys;
        res_t r;
        for (int k = 0; k < ITER; k++) begin
            xs = x >>> k;
            ys = y >>> k;
            if (z >= 0) begin
                x = wrapn(x - ys, 14);
                y = wrapn(y + xs, 14);
                z = wrapn(z - atan_ref(k), 12);
            end else begin
                x = wrapn(x + ys, 14);
                y = wrapn(y - xs, 14);
                z = wrapn(z + atan_ref(k), 12);
            end
        end
        r.x = satn(x);
        r.y = satn(y);
        r.z = z;
        return r;
    endfunction

    // Per-cycle compare: handshake exclusivity, done ordering, held outputs
    initial begin
        held = '{0, 0, 0};
        forever begin
            @(negedge clk);
            if (rst) begin
                held = '{0, 0, 0};
                check_eq("rst_busy", int'(busy), 0);
                check_eq("rst_done", int'(done), 0);
            end else begin
                check_eq("busy_done_excl", int'(busy && done), 0);
                if (done) begin
                    checks++;
                    if (expq.size() == 0) begin
                        errors++;
                        $display("FAIL unexpected_done: got done=1 expected no pending op at %0t", $time);
                    end else begin
                        held = expq.pop_front();
                    end
                end
            end
            check_eq("x_out", int'(x_out), held.x);
            check_eq("y_out", int'(y_out), held.y);
            check_eq("theda_out", int'(theda_out), held.z);
        end
    end

    function automatic int rnd12();
        return int'($urandom_range(0, 4095)) - 2048;
    endfunction

    // One operation from IDLE, checking latency and busy length
    task automatic run_op(input int xi, input int yi, input int zi, input bit poke,
                          output res_t m);
        int  busy_cnt = 0;
        bit  got = 1'b0;
        @(negedge clk);
        x_in = 12'(xi);
        y_in = 12'(yi);
        theda_in = 12'(zi);
        start = 1'b1;
        m = model(xi, yi, zi);
        expq.push_back(m);
        @(posedge clk);
        #1;
        start = 1'b0;
        x_in = 12'(rnd12());
        y_in = 12'(rnd12());
        theda_in = 12'(rnd12());
        for (int c = 1; c <= ITER + 5; c++) begin
            @(negedge clk);
            if (busy) busy_cnt++;
            if (poke && c == 4) start = 1'b1;
            if (poke && c == 5) start = 1'b0;
            if (done) begin
                got = 1'b1;
                check_eq("latency", c, ITER + 1);
                break;
            end
        end
        check_eq("done_seen", int'(got), 1);
        check_eq("busy_cycles", busy_cnt, ITER);
    endtask

    // Continuous start with new operands offered at every DONE
    task automatic run_b2b(input int n);
        int   cnt;
        bit   got;
        res_t m;
        @(negedge clk);
        x_in = 12'(rnd12());
        y_in = 12'(rnd12());
        theda_in = 12'($urandom_range(0, 3216)) - 12'd1608;
        start = 1'b1;
        expq.push_back(model(int'(x_in), int'(y_in), int'(theda_in)));
        for (int k = 0; k < n; k++) begin
            cnt = 0;
            got = 1'b0;
            for (int c = 1; c <= ITER + 5; c++) begin
                @(negedge clk);
                cnt = c;
                if (done) begin
                    got = 1'b1;
                    break;
                end
            end
            check_eq("b2b_done_seen", int'(got), 1);
            check_eq("b2b_interval", cnt, ITER + 1);
            if (k < n - 1) begin
                x_in = 12'(rnd12());
                y_in = 12'(rnd12());
                theda_in = 12'($urandom_range(0, 3216)) - 12'd1608;
                m = model(int'(x_in), int'(y_in), int'(theda_in));
                expq.push_back(m);
            end else begin
                start = 1'b0;
            end
        end
    endtask

    initial begin
        res_t m;
        int   zi;
        repeat (3) @(negedge clk);
        rst = 1'b0;

        run_op(622, 0, 0, 1'b0, m);
        check_rng("m0_x", m.x, 1020, 1028);
        check_rng("m0_y", m.y, -4, 4);
        check_rng("m0_z", m.z, -2, 2);
        check_rng("dut0_x", int'(x_out), 1020, 1028);
        check_rng("dut0_y", int'(y_out), -4, 4);
        check_rng("dut0_z", int'(theda_out), -2, 2);

        run_op(622, 0, 804, 1'b1, m);
        check_rng("m45_x", m.x, 720, 728);
        check_rng("m45_y", m.y, 720, 728);
        check_rng("dut45_x", int'(x_out), 720, 728);
        check_rng("dut45_y", int'(y_out), 720, 728);
        repeat (3) @(negedge clk);

        run_op(622, 0, -1608, 1'b0, m);
        check_rng("m90_x", m.x, -4, 4);
        check_rng("m90_y", m.y, -1028, -1020);
        check_rng("dut90_x", int'(x_out), -4, 4);
        check_rng("dut90_y", int'(y_out), -1028, -1020);

        run_op(2047, 2047, 0, 1'b0, m);
        check_eq("sat_model", int'(m.x == 2047 || m.y == 2047), 1);
        check_eq("sat_dut", int'(x_out == 12'sd2047 || y_out == 12'sd2047), 1);
        check_rng("sat_x_pos", int'(x_out), 0, 2047);
        check_rng("sat_y_pos", int'(y_out), 0, 2047);

        run_op(0, 0, rnd12(), 1'b0, m);
        check_eq("zero_x", int'(x_out), 0);
        check_eq("zero_y", int'(y_out), 0);

        for (int i = 0; i < 20; i++) begin
            zi = ($urandom_range(0, 3) == 0) ? rnd12()
                                             : int'($urandom_range(0, 3216)) - 1608;
            run_op(rnd12(), rnd12(), zi, 1'b0, m);
        end

        run_b2b(8);
        repeat (2) @(negedge clk);

        // Abort mid-RUN with reset
        @(negedge clk);
        x_in = 12'sd500;
        y_in = -12'sd300;
        theda_in = 12'sd400;
        start = 1'b1;
        expq.push_back(model(500, -300, 400));
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (6) @(negedge clk);
        #2;
        rst = 1'b1;
        expq.delete();
        #1;
        check_eq("abort_busy", int'(busy), 0);
        check_eq("abort_done", int'(done), 0);
        check_eq("abort_x", int'(x_out), 0);
        check_eq("abort_y", int'(y_out), 0);
        check_eq("abort_z", int'(theda_out), 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;

        run_op(-700, 900, -1000, 1'b0, m);
        repeat (4) @(negedge clk);
        check_eq("queue_drained", expq.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
